// File: rtl/conv_mac_engine.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | conv_mac_engine : streaming 1-D convolution, K_MAX parallel taps, rev 1.0 |
// +-------------------------------------------------------------------------+
module conv_mac_engine #(
  parameter int INPUT_BW     = 8,
  parameter int PSUM_BW      = 32,
  parameter int K_MAX        = 5,
  parameter int OC_MAX       = 64,
  parameter int IMG_W_BW     = 6,
  parameter int OC_BW        = 8,
  parameter int PSUM_ADDR_BW = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start_i,
  input  logic [$clog2(K_MAX+1)-1:0]        cfg_k_i,
  input  logic [IMG_W_BW-1:0]               cfg_img_w_i,
  input  logic [OC_BW-1:0]                  cfg_oc_i,
  input  logic [2:0]                        cfg_stride_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              cfg_err_o,
  input  logic                              w_valid_i,
  output logic                              w_ready_o,
  input  logic signed [INPUT_BW-1:0]        w_data_i,
  input  logic                              ia_valid_i,
  output logic                              ia_ready_o,
  input  logic signed [INPUT_BW-1:0]        ia_data_i,
  output logic                              psum_valid_o,
  input  logic                              psum_ready_i,
  output logic signed [PSUM_BW-1:0]         psum_data_o,
  output logic [PSUM_ADDR_BW-1:0]           psum_addr_o
);

  localparam int K_BW    = $clog2(K_MAX+1);
  localparam int CNT_BW  = K_BW + 3;
  localparam int WA_BW   = $clog2(OC_MAX*K_MAX);
  localparam int PROD_BW = 2*INPUT_BW;
  localparam int POS_BW  = IMG_W_BW + 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_FILL    = 3'd2,
    S_COMPUTE = 3'd3,
    S_SLIDE   = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t                          state_q, state_d;
  logic [K_BW-1:0]                 k_q, k_d;
  logic [2:0]                      s_q, s_d;
  logic [IMG_W_BW-1:0]             img_w_q, img_w_d;
  logic [OC_BW-1:0]                oc_q, oc_d;
  logic                            cfg_err_q, cfg_err_d;
  logic                            done_q, done_d;
  logic [OC_BW-1:0]                w_oc_q, w_oc_d;
  logic [K_BW-1:0]                 w_k_q, w_k_d;
  logic [CNT_BW-1:0]               ph_cnt_q, ph_cnt_d;
  logic [POS_BW-1:0]               ia_pos_q, ia_pos_d;
  logic [OC_BW-1:0]                oc_cnt_q, oc_cnt_d;
  logic [PSUM_ADDR_BW-1:0]         x_q, x_d;
  logic [PSUM_ADDR_BW-1:0]         iss_addr_q, iss_addr_d;

  logic signed [INPUT_BW-1:0]      win_q [K_MAX];
  logic signed [INPUT_BW-1:0]      win_d [K_MAX];
  logic signed [INPUT_BW-1:0]      w_mem [OC_MAX*K_MAX];

  logic signed [PROD_BW-1:0]       prod_q [K_MAX];
  logic signed [PROD_BW-1:0]       prod_d [K_MAX];
  logic                            s1_valid_q, s1_valid_d;
  logic [PSUM_ADDR_BW-1:0]         s1_addr_q, s1_addr_d;
  logic signed [PSUM_BW-1:0]       psum_q, psum_d;
  logic                            psum_valid_q, psum_valid_d;
  logic [PSUM_ADDR_BW-1:0]         psum_addr_q, psum_addr_d;

  logic                            stall, issue, w_hs, ia_hs, ia_ready;
  logic                            cfg_ok, ia_left, more_win, pipe_empty;
  logic [WA_BW-1:0]                w_wr_addr, w_rd_base;
  logic signed [PSUM_BW-1:0]       tap_sum;

  // A held output back-pressures the whole pipe, including issue.
  assign stall      = psum_valid_q & ~psum_ready_i;
  assign issue      = (state_q == S_COMPUTE) & ~stall;
  assign ia_left    = ia_pos_q < POS_BW'(img_w_q);
  assign more_win   = (ia_pos_q + POS_BW'(s_q)) <= POS_BW'(img_w_q);
  assign pipe_empty = ~s1_valid_q & ~psum_valid_q;
  assign ia_ready   = (state_q == S_FILL) | (state_q == S_SLIDE) |
                      ((state_q == S_DRAIN) & ia_left);
  assign w_hs       = w_valid_i & (state_q == S_LOAD_W);
  assign ia_hs      = ia_valid_i & ia_ready;
  assign w_wr_addr  = WA_BW'(w_oc_q) * WA_BW'(K_MAX) + WA_BW'(w_k_q);
  assign w_rd_base  = WA_BW'(oc_cnt_q) * WA_BW'(K_MAX);

  assign cfg_ok = (cfg_k_i != '0) && (int'(cfg_k_i) <= K_MAX) &&
                  (cfg_stride_i != 3'd0) && (cfg_oc_i != '0) &&
                  (int'(cfg_oc_i) <= OC_MAX) && (int'(cfg_img_w_i) >= int'(cfg_k_i));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    s_d        = s_q;
    img_w_d    = img_w_q;
    oc_d       = oc_q;
    cfg_err_d  = cfg_err_q;
    done_d     = 1'b0;
    w_oc_d     = w_oc_q;
    w_k_d      = w_k_q;
    ph_cnt_d   = ph_cnt_q;
    ia_pos_d   = ia_pos_q;
    oc_cnt_d   = oc_cnt_q;
    x_d        = x_q;
    iss_addr_d = iss_addr_q;
    if (ia_hs) ia_pos_d = ia_pos_q + POS_BW'(1);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            k_d        = cfg_k_i;
            s_d        = cfg_stride_i;
            img_w_d    = cfg_img_w_i;
            oc_d       = cfg_oc_i;
            cfg_err_d  = 1'b0;
            w_oc_d     = '0;
            w_k_d      = '0;
            ph_cnt_d   = '0;
            ia_pos_d   = '0;
            oc_cnt_d   = '0;
            x_d        = '0;
            iss_addr_d = '0;
            state_d    = S_LOAD_W;
          end else begin
            cfg_err_d = 1'b1;
            done_d    = 1'b1;
          end
        end
      end
      S_LOAD_W: begin
        if (w_hs) begin
          if (w_k_q == k_q - K_BW'(1)) begin
            w_k_d = '0;
            if (w_oc_q == oc_q - OC_BW'(1)) state_d = S_FILL;
            else                            w_oc_d  = w_oc_q + OC_BW'(1);
          end else begin
            w_k_d = w_k_q + K_BW'(1);
          end
        end
      end
      S_FILL: begin
        if (ia_hs) begin
          if (ph_cnt_q == CNT_BW'(k_q) - CNT_BW'(1)) begin
            ph_cnt_d = '0;
            state_d  = S_COMPUTE;
          end else begin
            ph_cnt_d = ph_cnt_q + CNT_BW'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (issue) begin
          if (oc_cnt_q == oc_q - OC_BW'(1)) begin
            oc_cnt_d   = '0;
            x_d        = x_q + PSUM_ADDR_BW'(1);
            iss_addr_d = x_q + PSUM_ADDR_BW'(1);
            state_d    = more_win ? S_SLIDE : S_DRAIN;
          end else begin
            oc_cnt_d   = oc_cnt_q + OC_BW'(1);
            iss_addr_d = iss_addr_q + PSUM_ADDR_BW'(img_w_q);
          end
        end
      end
      S_SLIDE: begin
        if (ia_hs) begin
          if (ph_cnt_q == CNT_BW'(s_q) - CNT_BW'(1)) begin
            ph_cnt_d = '0;
            state_d  = S_COMPUTE;
          end else begin
            ph_cnt_d = ph_cnt_q + CNT_BW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!ia_left && pipe_empty) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Oldest sample sits at tap 0, newest lands at tap K-1.
  always_comb begin
    for (int i = 0; i < K_MAX; i++) win_d[i] = win_q[i];
    if (ia_hs) begin
      for (int i = 0; i < K_MAX-1; i++) win_d[i] = win_q[i+1];
      for (int i = 0; i < K_MAX; i++) begin
        if (i == int'(k_q) - 1) win_d[i] = ia_data_i;
      end
    end
  end

  always_comb begin
    tap_sum = '0;
    for (int i = 0; i < K_MAX; i++) begin
      tap_sum = tap_sum + {{(PSUM_BW-PROD_BW){prod_q[i][PROD_BW-1]}}, prod_q[i]};
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_addr_d    = s1_addr_q;
    psum_valid_d = psum_valid_q;
    psum_d       = psum_q;
    psum_addr_d  = psum_addr_q;
    for (int i = 0; i < K_MAX; i++) prod_d[i] = prod_q[i];
    if (!stall) begin
      s1_valid_d   = issue;
      s1_addr_d    = iss_addr_q;
      psum_valid_d = s1_valid_q;
      psum_d       = tap_sum;
      psum_addr_d  = s1_addr_q;
      for (int i = 0; i < K_MAX; i++) begin
        if (i < int'(k_q)) prod_d[i] = PROD_BW'(win_q[i]) * PROD_BW'(w_mem[w_rd_base + WA_BW'(i)]);
        else               prod_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      s_q          <= '0;
      img_w_q      <= '0;
      oc_q         <= '0;
      cfg_err_q    <= 1'b0;
      done_q       <= 1'b0;
      w_oc_q       <= '0;
      w_k_q        <= '0;
      ph_cnt_q     <= '0;
      ia_pos_q     <= '0;
      oc_cnt_q     <= '0;
      x_q          <= '0;
      iss_addr_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      psum_valid_q <= 1'b0;
      psum_q       <= '0;
      psum_addr_q  <= '0;
      for (int i = 0; i < K_MAX; i++) begin
        win_q[i]  <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      s_q          <= s_d;
      img_w_q      <= img_w_d;
      oc_q         <= oc_d;
      cfg_err_q    <= cfg_err_d;
      done_q       <= done_d;
      w_oc_q       <= w_oc_d;
      w_k_q        <= w_k_d;
      ph_cnt_q     <= ph_cnt_d;
      ia_pos_q     <= ia_pos_d;
      oc_cnt_q     <= oc_cnt_d;
      x_q          <= x_d;
      iss_addr_q   <= iss_addr_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      psum_valid_q <= psum_valid_d;
      psum_q       <= psum_d;
      psum_addr_q  <= psum_addr_d;
      for (int i = 0; i < K_MAX; i++) begin
        win_q[i]  <= win_d[i];
        prod_q[i] <= prod_d[i];
      end
    end
  end

  // Weight storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_hs) w_mem[w_wr_addr] <= w_data_i;
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign cfg_err_o    = cfg_err_q;
  assign w_ready_o    = (state_q == S_LOAD_W);
  assign ia_ready_o   = ia_ready;
  assign psum_valid_o = psum_valid_q;
  assign psum_data_o  = psum_q;
  assign psum_addr_o  = psum_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_engine.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_conv_mac_engine : directed + scoreboard bench for conv_mac_engine     |
// +-------------------------------------------------------------------------+
module tb_conv_mac_engine;

  typedef struct {
    logic signed [31:0] data;
    logic [11:0]        addr;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [2:0]         cfg_k;
  logic [5:0]         cfg_img_w;
  logic [7:0]         cfg_oc;
  logic [2:0]         cfg_stride;
  logic               busy, done, cfg_err;
  logic               w_valid, w_ready;
  logic signed [7:0]  w_data;
  logic               ia_valid, ia_ready;
  logic signed [7:0]  ia_data;
  logic               psum_valid, psum_ready;
  logic signed [31:0] psum_data;
  logic [11:0]        psum_addr;

  exp_t              sb[$];
  logic signed [7:0] w_src[$];
  logic signed [7:0] ia_src[$];
  int checks, errors;
  int w_idx, ia_idx, done_cnt;

  always #5 clk = ~clk;

  conv_mac_engine dut (
    .clk(clk), .reset(reset), .start_i(start),
    .cfg_k_i(cfg_k), .cfg_img_w_i(cfg_img_w), .cfg_oc_i(cfg_oc), .cfg_stride_i(cfg_stride),
    .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
    .ia_valid_i(ia_valid), .ia_ready_o(ia_ready), .ia_data_i(ia_data),
    .psum_valid_o(psum_valid), .psum_ready_i(psum_ready),
    .psum_data_o(psum_data), .psum_addr_o(psum_addr)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void push_expected(input int k, input int s, input int imgw, input int oc);
    int ow;
    longint acc;
    exp_t e;
    ow = (imgw - k) / s + 1;
    for (int x = 0; x < ow; x++) begin
      for (int o = 0; o < oc; o++) begin
        acc = 0;
        for (int j = 0; j < k; j++)
          acc += longint'(ia_src[x*s+j]) * longint'(w_src[o*k+j]);
        e.data = acc[31:0];
        e.addr = 12'((o*imgw + x) % 4096);
        sb.push_back(e);
      end
    end
  endfunction

  // Drives both streams each negedge; psum transfers are scored at the
  // negedge before the posedge that completes them.
  task automatic run_job(input int k, input int s, input int imgw, input int oc,
                         input bit rnd, input bit inject, input bit abort);
    int cyc, tail;
    bit hit;
    exp_t e;
    w_idx = 0; ia_idx = 0; done_cnt = 0;
    push_expected(k, s, imgw, oc);
    @(negedge clk);
    cfg_k = 3'(k); cfg_stride = 3'(s); cfg_img_w = 6'(imgw); cfg_oc = 8'(oc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; tail = 0; hit = 1'b0;
    while (cyc < 3000 && tail < 4 && !hit) begin
      start = inject && (cyc == 3);
      if (start) begin
        cfg_k = 3'd1; cfg_oc = 8'd1; cfg_stride = 3'd0;
      end
      w_valid    = (w_idx < w_src.size()) && (!rnd || $urandom_range(0, 3) != 0);
      w_data     = w_valid ? w_src[w_idx] : 8'sd0;
      ia_valid   = (ia_idx < ia_src.size()) && (!rnd || $urandom_range(0, 3) != 0);
      ia_data    = ia_valid ? ia_src[ia_idx] : 8'sd0;
      psum_ready = !rnd || ($urandom_range(0, 2) != 0);
      if (w_valid && w_ready) w_idx++;
      if (ia_valid && ia_ready) ia_idx++;
      if (psum_valid && psum_ready) begin
        if (sb.size() == 0) chk("extra_psum", 1, 0);
        else begin
          e = sb.pop_front();
          chk("psum_data", longint'(psum_data), longint'(e.data));
          chk("psum_addr", longint'(psum_addr), longint'(e.addr));
        end
      end
      if (done) done_cnt++;
      if (done_cnt > 0) tail++;
      if (abort && busy && !w_ready && !ia_ready && ia_idx > 0) hit = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("job_timeout", longint'(cyc >= 3000), 0);
    if (abort) chk("reached_compute", longint'(hit), 1);
    else begin
      chk("done_pulses", done_cnt, 1);
      chk("sb_left", sb.size(), 0);
      chk("ia_consumed", ia_idx, ia_src.size());
      chk("w_consumed", w_idx, w_src.size());
      chk("busy_after", longint'(busy), 0);
      chk("cfg_err_after", longint'(cfg_err), 0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_cfg_err"}, longint'(cfg_err), 0);
    chk({tag, "_w_ready"}, longint'(w_ready), 0);
    chk({tag, "_ia_ready"}, longint'(ia_ready), 0);
    chk({tag, "_psum_valid"}, longint'(psum_valid), 0);
    chk({tag, "_psum_data"}, longint'(psum_data), 0);
    chk({tag, "_psum_addr"}, longint'(psum_addr), 0);
  endtask

  initial begin
    int seen;
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0;
    cfg_k = '0; cfg_img_w = '0; cfg_oc = '0; cfg_stride = '0;
    w_valid = 1'b0; w_data = '0; ia_valid = 1'b0; ia_data = '0; psum_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    reset = 1'b0;

    // K=3 S=1 W=5 OC=2
    w_src = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, -8'sd1, 8'sd2};
    ia_src.delete();
    for (int i = 1; i <= 5; i++) ia_src.push_back(8'(i));
    run_job(3, 1, 5, 2, 1'b0, 1'b0, 1'b0);

    // K=3 S=2 W=8 OC=1, one sample left for DRAIN; extra start while busy
    w_src = '{8'sd1, 8'sd0, 8'sd0};
    ia_src.delete();
    for (int i = 1; i <= 8; i++) ia_src.push_back(8'(i));
    run_job(3, 2, 8, 1, 1'b0, 1'b1, 1'b0);

    // Most-negative operands on every tap
    w_src.delete(); ia_src.delete();
    for (int i = 0; i < 5; i++) begin
      w_src.push_back(-8'sd128);
      ia_src.push_back(-8'sd128);
    end
    run_job(5, 1, 5, 1, 1'b0, 1'b0, 1'b0);

    // Random data, random valid and psum_ready
    w_src.delete(); ia_src.delete();
    for (int i = 0; i < 12; i++) w_src.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 13; i++) ia_src.push_back(8'($urandom_range(0, 255)));
    run_job(4, 2, 13, 3, 1'b1, 1'b0, 1'b0);

    w_src.delete(); ia_src.delete();
    for (int i = 0; i < 20; i++) w_src.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 21; i++) ia_src.push_back(8'($urandom_range(0, 255)));
    run_job(5, 3, 21, 4, 1'b1, 1'b0, 1'b0);

    // Illegal stride
    @(negedge clk);
    cfg_k = 3'd3; cfg_img_w = 6'd5; cfg_oc = 8'd2; cfg_stride = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_cfg_err", longint'(cfg_err), 1);
    chk("err_done", longint'(done), 1);
    chk("err_busy", longint'(busy), 0);
    chk("err_w_ready", longint'(w_ready), 0);
    @(negedge clk);
    chk("err_done_pulse", longint'(done), 0);
    chk("err_sticky", longint'(cfg_err), 1);
    chk("err_ia_ready", longint'(ia_ready), 0);

    // Reset while in COMPUTE, then a fresh run
    w_src = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, -8'sd1, 8'sd2};
    ia_src.delete();
    for (int i = 1; i <= 5; i++) ia_src.push_back(8'(i));
    run_job(3, 1, 5, 2, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    w_valid = 1'b0; ia_valid = 1'b0; psum_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_outputs_zero("abort");
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (psum_valid || busy) seen++;
    end
    chk("abort_quiet", seen, 0);
    sb.delete();
    run_job(3, 1, 5, 2, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
